mem_arbiter: RTL and testbench

- Two-requester arbiter for the shared 8-bit, 64K-byte memory bus used by the cpu16 core.
- Requester A (core) and requester B (DMA or video fetch) each get a request/acknowledge port.
- The memory side drives a synchronous-read RAM: address and we in one cycle, read data valid on the following cycle.
- Serialises accesses, one outstanding access at a time, with round-robin or fixed-priority selection.

---
 rtl/mem_arbiter_if.sv | 17 +
 rtl/mem_arbiter.sv | 59 +++++
 tb/tb_mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and memory-side bus shared by the arbiter and its users
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic a_req, a_we, a_ack, b_req, b_we, b_ack, mem_we, busy;
  logic [AW-1:0] a_address, b_address, mem_address;
  logic [DW-1:0] a_out, a_in, b_out, b_in, mem_out, mem_in;
  modport slave (
    input  a_req, a_address, a_out, a_we, b_req, b_address, b_out, b_we, mem_in,
    output a_in, a_ack, b_in, b_ack, mem_address, mem_out, mem_we, busy
  );
  modport master (
    output a_req, a_address, a_out, a_we, b_req, b_address, b_out, b_we, mem_in,
    input  a_in, a_ack, b_in, b_ack, mem_address, mem_out, mem_we, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two requesters onto one synchronous-read memory, one 4-cycle access at a time
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int FIXED_PRIO = 0
) (
  input logic clock,
  input logic reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DATA, ACK} state_t;
  state_t state, nxt;
  logic owner_b, last_b, wr, sel_b, sel_we, grant, finish;
  logic [AW-1:0] sel_address;
  logic [DW-1:0] sel_out;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? ((bus.a_req | bus.b_req) ? ISSUE : IDLE) :
          state == ISSUE ? DATA : state == DATA ? ACK : IDLE;
  // on a tie, B wins only under fixed priority or when A was served last
  always_comb begin
    sel_b = bus.b_req & (~bus.a_req | (FIXED_PRIO != 0) | ~last_b);
    grant = (state == IDLE) & (bus.a_req | bus.b_req);
    finish = state == DATA;
    sel_address = sel_b ? bus.b_address : bus.a_address;
    sel_out = sel_b ? bus.b_out : bus.a_out;
    sel_we = sel_b ? bus.b_we : bus.a_we;
    bus.busy = state != IDLE;
  end
  // mem_we is only ever set by a grant, so it drops at the edge ending ISSUE
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bus.mem_address <= '0;
      bus.mem_out <= '0;
      bus.mem_we <= 1'b0;
      bus.a_ack <= 1'b0;
      bus.b_ack <= 1'b0;
      bus.a_in <= '0;
      bus.b_in <= '0;
      owner_b <= 1'b0;
      last_b <= 1'b1;
      wr <= 1'b0;
    end else begin
      bus.mem_we <= grant & sel_we;
      bus.a_ack <= finish & ~owner_b;
      bus.b_ack <= finish & owner_b;
      if (grant) begin
        bus.mem_address <= sel_address;
        bus.mem_out <= sel_out;
        owner_b <= sel_b;
        last_b <= sel_b;
        wr <= sel_we;
      end
      if (finish & ~wr & ~owner_b) bus.a_in <= bus.mem_in;
      if (finish & ~wr & owner_b) bus.b_in <= bus.mem_in;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: round-robin and fixed-priority arbiters side by side, sharing requester stimulus
module tb_mem_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_address = '0, b_address = '0;
  logic [7:0] a_out = '0, b_out = '0;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {logic who; logic [7:0] data; int cyc;} exp_t;
  typedef struct {logic who; logic we; logic [15:0] addr; logic [7:0] data; logic [7:0] exp;} vec_t;
  exp_t q0[$], q1[$];
  vec_t vt[11];
  logic [7:0] m0 [0:65535];
  logic [7:0] m1 [0:65535];
  mem_arbiter_if #(.AW(16), .DW(8)) i0 ();
  mem_arbiter_if #(.AW(16), .DW(8)) i1 ();
  mem_arbiter #(.AW(16), .DW(8), .FIXED_PRIO(0)) dut0 (.clock(clock), .reset(reset), .bus(i0));
  mem_arbiter #(.AW(16), .DW(8), .FIXED_PRIO(1)) dut1 (.clock(clock), .reset(reset), .bus(i1));
  assign {i0.a_req, i0.a_we, i0.a_address, i0.a_out, i0.b_req, i0.b_we, i0.b_address, i0.b_out} =
         {a_req, a_we, a_address, a_out, b_req, b_we, b_address, b_out};
  assign {i1.a_req, i1.a_we, i1.a_address, i1.a_out, i1.b_req, i1.b_we, i1.b_address, i1.b_out} =
         {a_req, a_we, a_address, a_out, b_req, b_we, b_address, b_out};
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // synchronous-read RAM per arbiter: data valid the cycle after the address
  always @(posedge clock) begin
    if (i0.mem_we) m0[i0.mem_address] <= i0.mem_out;
    if (i1.mem_we) m1[i1.mem_address] <= i1.mem_out;
    i0.mem_in <= m0[i0.mem_address];
    i1.mem_in <= m1[i1.mem_address];
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask
  task automatic chk_ack(input int d, input logic aa, input logic ab, input logic [7:0] ai, input logic [7:0] bi);
    exp_t e;
    if (!(aa || ab)) return;
    check($sformatf("dut%0d_ack_onehot", d), {31'b0, aa & ab}, 0);
    if (d == 0 && q0.size() > 0) e = q0.pop_front();
    else if (d == 1 && q1.size() > 0) e = q1.pop_front();
    else begin
      checks++;
      failures++;
      $display("FAIL dut%0d_unexpected_ack at cycle %0d: a_ack=%b b_ack=%b required none", d, cyc, aa, ab);
      return;
    end
    check($sformatf("dut%0d_ack_who", d), {31'b0, ab}, {31'b0, e.who});
    check($sformatf("dut%0d_ack_cycle", d), cyc, e.cyc);
    check($sformatf("dut%0d_ack_data", d), ab ? bi : ai, e.data);
  endtask
  always @(negedge clock)
    if (!reset) begin
      chk_ack(0, i0.a_ack, i0.b_ack, i0.a_in, i0.b_in);
      chk_ack(1, i1.a_ack, i1.b_ack, i1.a_in, i1.b_in);
    end
  task automatic drive(input logic who, input logic we, input logic [15:0] addr, input logic [7:0] data);
    if (who) begin b_req = 1'b1; b_we = we; b_address = addr; b_out = data; end
    else begin a_req = 1'b1; a_we = we; a_address = addr; a_out = data; end
  endtask
  // one lone access with per-cycle bus checks; ack timing/data go through the scoreboard
  task automatic run_vec(input vec_t v);
    int t;
    t = cyc;
    drive(v.who, v.we, v.addr, v.data);
    q0.push_back('{who: v.who, data: v.exp, cyc: t + 3});
    q1.push_back('{who: v.who, data: v.exp, cyc: t + 3});
    @(negedge clock);
    check("idle_busy0", {31'b0, i0.busy}, 0);
    check("idle_busy1", {31'b0, i1.busy}, 0);
    @(negedge clock);
    check("issue_addr0", i0.mem_address, v.addr);
    check("issue_addr1", i1.mem_address, v.addr);
    check("issue_we0", {31'b0, i0.mem_we}, {31'b0, v.we});
    check("issue_we1", {31'b0, i1.mem_we}, {31'b0, v.we});
    check("issue_busy0", {31'b0, i0.busy}, 1);
    @(negedge clock);
    check("data_addr0", i0.mem_address, v.addr);
    check("data_addr1", i1.mem_address, v.addr);
    check("data_we0", {31'b0, i0.mem_we}, 0);
    check("data_we1", {31'b0, i1.mem_we}, 0);
    @(negedge clock);
    check("ack_we0", {31'b0, i0.mem_we}, 0);
    check("ack_busy1", {31'b0, i1.busy}, 1);
    @(posedge clock);
    #1;
    if (v.who) b_req = 1'b0;
    else a_req = 1'b0;
  endtask
  initial begin
    int t;
    for (int i = 0; i < 65536; i++) begin m0[i] = 8'h00; m1[i] = 8'h00; end
    m0[16'h1234] = 8'h5A; m1[16'h1234] = 8'h5A;
    m0[16'h0200] = 8'h3C; m1[16'h0200] = 8'h3C;
    vt[0]  = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'h5A};
    vt[1]  = '{1'b1, 1'b1, 16'h0100, 8'hC3, 8'h3C};
    vt[2]  = '{1'b0, 1'b0, 16'h0100, 8'h00, 8'hC3};
    vt[3]  = '{1'b0, 1'b1, 16'h0200, 8'h22, 8'hC3};
    vt[4]  = '{1'b1, 1'b0, 16'h0200, 8'h00, 8'h22};
    vt[5]  = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'h5A};
    vt[6]  = '{1'b0, 1'b1, 16'hFFFF, 8'hEE, 8'hC3};
    vt[7]  = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'hEE};
    vt[8]  = '{1'b1, 1'b1, 16'h0000, 8'h77, 8'h5A};
    vt[9]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h77};
    vt[10] = '{1'b1, 1'b0, 16'h0100, 8'h00, 8'hC3};
    repeat (2) @(posedge clock);
    #1;
    check("rst_ctl0", {12'b0, i0.busy, i0.mem_we, i0.a_ack, i0.b_ack, i0.mem_address}, 0);
    check("rst_ctl1", {12'b0, i1.busy, i1.mem_we, i1.a_ack, i1.b_ack, i1.mem_address}, 0);
    check("rst_data0", {8'b0, i0.mem_out, i0.a_in, i0.b_in}, 0);
    check("rst_data1", {8'b0, i1.mem_out, i1.a_in, i1.b_in}, 0);
    reset = 1'b0;
    // both requesting: round-robin alternates from A, fixed priority starves A until B drops
    t = cyc;
    drive(1'b0, 1'b0, 16'h1234, 8'h00);
    drive(1'b1, 1'b0, 16'h0200, 8'h00);
    for (int k = 0; k < 4; k++) begin
      q0.push_back('{who: k[0], data: k[0] ? 8'h3C : 8'h5A, cyc: t + 3 + 4 * k});
      q1.push_back('{who: 1'b1, data: 8'h3C, cyc: t + 3 + 4 * k});
    end
    q0.push_back('{who: 1'b0, data: 8'h5A, cyc: t + 19});
    q1.push_back('{who: 1'b0, data: 8'h5A, cyc: t + 19});
    repeat (16) @(posedge clock);
    #1;
    b_req = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    a_req = 1'b0;
    for (int i = 0; i < 11; i++) run_vec(vt[i]);
    // reset during ISSUE of a write, then the held request is served afresh
    drive(1'b0, 1'b1, 16'h3000, 8'h99);
    @(posedge clock);
    #1;
    check("pre_rst_we0", {31'b0, i0.mem_we}, 1);
    check("pre_rst_we1", {31'b0, i1.mem_we}, 1);
    reset = 1'b1;
    #1;
    check("rst_issue0", {29'b0, i0.mem_we, i0.busy, i0.a_ack}, 0);
    check("rst_issue1", {29'b0, i1.mem_we, i1.busy, i1.a_ack}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    t = cyc;
    q0.push_back('{who: 1'b0, data: 8'h00, cyc: t + 3});
    q1.push_back('{who: 1'b0, data: 8'h00, cyc: t + 3});
    repeat (4) @(posedge clock);
    #1;
    a_req = 1'b0;
    run_vec('{1'b0, 1'b0, 16'h3000, 8'h00, 8'h99});
    run_vec('{1'b1, 1'b0, 16'h0000, 8'h00, 8'h77});
    repeat (10) begin
      @(negedge clock);
      check("hold_ctl0", {30'b0, i0.busy, i0.mem_we}, 0);
      check("hold_ctl1", {30'b0, i1.busy, i1.mem_we}, 0);
      check("hold_in0", {16'b0, i0.a_in, i0.b_in}, 32'h9977);
      check("hold_in1", {16'b0, i1.a_in, i1.b_in}, 32'h9977);
      check("hold_addr0", i0.mem_address, 32'h0000);
      check("hold_addr1", i1.mem_address, 32'h0000);
    end
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
